// File: rtl/pe_row_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pe_row_feeder
// Purpose  : Upstream feeder for the PE top level. Takes a configuration word,
//            a filter stream and a pixel stream (all valid/ready). The filter
//            is written once per configuration into the PE filter buffer. The
//            ifmap is then written one row at a time into the PE ifmap buffer,
//            each word tagged with start-of-row / end-of-row flags. After each
//            row a one-cycle start pulse is issued and the block waits for the
//            PE done indication before the next row (or returns to IDLE after
//            the row flagged as the last one).
//
// Ports    : clk, rst (async, active-low)
//            cfg_valid/cfg_row_len/cfg_filter_size/cfg_stride -> cfg_ready,
//              cfg_err (one-cycle pulse on a rejected configuration)
//            filt_valid/filt_data -> filt_ready       filter stream
//            pix_valid/pix_data/pix_last_row -> pix_ready  pixel stream
//            IFMap_out/wen_IFMap_buffer              ifmap buffer write port
//            Filter_out/wen_Filter_buffer            filter buffer write port
//            stride/filter_size                      held configuration
//            start (pulse), pe_done (in), busy
//
// Revision : 1.0 - initial release
// ============================================================================
module pe_row_feeder #(
  parameter int DATA_WIDTH           = 16,
  parameter int IFMAP_WIDTH          = 18,
  parameter int FILTER_WIDTH         = 8,
  parameter int IFMAP_BUFFER_DEPTH   = 16,
  parameter int FILTER_BUFFER_DEPTH  = 16,
  parameter int ROW_LEN_SIZE         = 8,
  parameter int FILTER_SIZE_REG_SIZE = 8,
  parameter int STRIDE_SIZE          = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  // configuration channel
  input  logic                            cfg_valid,
  input  logic [ROW_LEN_SIZE-1:0]         cfg_row_len,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] cfg_filter_size,
  input  logic [STRIDE_SIZE-1:0]          cfg_stride,
  output logic                            cfg_ready,
  output logic                            cfg_err,
  // filter stream
  input  logic                            filt_valid,
  input  logic [FILTER_WIDTH-1:0]         filt_data,
  output logic                            filt_ready,
  // pixel stream
  input  logic                            pix_valid,
  input  logic [DATA_WIDTH-1:0]           pix_data,
  input  logic                            pix_last_row,
  output logic                            pix_ready,
  // PE buffer write ports
  output logic [IFMAP_WIDTH-1:0]          IFMap_out,
  output logic                            wen_IFMap_buffer,
  output logic [FILTER_WIDTH-1:0]         Filter_out,
  output logic                            wen_Filter_buffer,
  // held configuration and PE control
  output logic [STRIDE_SIZE-1:0]          stride,
  output logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
  output logic                            start,
  input  logic                            pe_done,
  output logic                            busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [31:0] ROW_MAX  = 32'(IFMAP_BUFFER_DEPTH);
  localparam logic [31:0] FILT_MAX = 32'(FILTER_BUFFER_DEPTH);

  localparam logic [ROW_LEN_SIZE-1:0]         ROW_ONE  = ROW_LEN_SIZE'(1);
  localparam logic [FILTER_SIZE_REG_SIZE-1:0] FILT_ONE = FILTER_SIZE_REG_SIZE'(1);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_FILT = 3'd1,
    LOAD_ROW  = 3'd2,
    KICK      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // --------------------------------------------------------------------------
  // Internal registers
  // --------------------------------------------------------------------------
  logic [ROW_LEN_SIZE-1:0]         row_len;
  logic [FILTER_SIZE_REG_SIZE-1:0] fcnt;
  logic [ROW_LEN_SIZE-1:0]         pcnt;
  logic                            last_f;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic cfg_bad;
  logic cfg_hs;
  logic filt_hs;
  logic pix_hs;
  logic filt_last;
  logic sor;
  logic eor;

  // A configuration is unusable when the row or the filter would not fit
  // the PE buffers, is empty, or the row is shorter than the filter (no
  // complete output position would exist).
  always_comb begin
    cfg_bad = 1'b0;
    if (cfg_row_len == '0)                             cfg_bad = 1'b1;
    if (32'(cfg_row_len) > ROW_MAX)                    cfg_bad = 1'b1;
    if (cfg_filter_size == '0)                         cfg_bad = 1'b1;
    if (32'(cfg_filter_size) > FILT_MAX)               cfg_bad = 1'b1;
    if (32'(cfg_row_len) < 32'(cfg_filter_size))       cfg_bad = 1'b1;
  end

  assign cfg_hs    = cfg_valid  & cfg_ready;
  assign filt_hs   = filt_valid & filt_ready;
  assign pix_hs    = pix_valid  & pix_ready;

  assign filt_last = (fcnt == (filter_size - FILT_ONE));
  assign sor       = (pcnt == '0);
  assign eor       = (pcnt == (row_len - ROW_ONE));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and ready/busy decode. Readies depend on state only, so an
  // upstream source may legally wait for ready before raising valid.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    cfg_ready  = 1'b0;
    filt_ready = 1'b0;
    pix_ready  = 1'b0;
    busy       = 1'b1;

    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid && !cfg_bad) begin
          state_nxt = LOAD_FILT;
        end
      end

      LOAD_FILT: begin
        filt_ready = 1'b1;
        if (filt_valid && filt_last) begin
          state_nxt = LOAD_ROW;
        end
      end

      LOAD_ROW: begin
        pix_ready = 1'b1;
        if (pix_valid && eor) begin
          state_nxt = KICK;
        end
      end

      // One cycle of separation so the eor write is in the buffer before
      // the registered start pulse reaches the PE.
      KICK: begin
        state_nxt = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (pe_done) begin
          state_nxt = last_f ? IDLE : LOAD_ROW;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Configuration hold registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_len     <= '0;
      stride      <= '0;
      filter_size <= '0;
    end else if (cfg_hs && !cfg_bad) begin
      row_len     <= cfg_row_len;
      stride      <= cfg_stride;
      filter_size <= cfg_filter_size;
    end
  end

  // --------------------------------------------------------------------------
  // Filter word counter: wraps to zero on the final filter word so it is
  // ready for the next configuration.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt <= '0;
    end else if (filt_hs) begin
      if (filt_last) begin
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FILT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel counter and last-row flag. The counter is left at row_len after
  // the eor word and is cleared when the PE reports the row complete.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt   <= '0;
      last_f <= 1'b0;
    end else begin
      if (pix_hs) begin
        pcnt <= pcnt + ROW_ONE;
        if (eor) begin
          last_f <= pix_last_row;
        end
      end else if ((state == WAIT_DONE) && pe_done) begin
        pcnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered write ports, start pulse and configuration error pulse.
  // Data registers hold their last value between writes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_Filter_buffer <= 1'b0;
      Filter_out        <= '0;
      wen_IFMap_buffer  <= 1'b0;
      IFMap_out         <= '0;
      start             <= 1'b0;
      cfg_err           <= 1'b0;
    end else begin
      wen_Filter_buffer <= filt_hs;
      if (filt_hs) begin
        Filter_out <= filt_data;
      end

      wen_IFMap_buffer <= pix_hs;
      if (pix_hs) begin
        IFMap_out <= {sor, eor, pix_data};
      end

      start   <= (state == KICK);
      cfg_err <= cfg_hs & cfg_bad;
    end
  end

endmodule
`default_nettype wire
